// File: rtl/contador_pkg.sv
// Shared types and defaults for the target-count stage.
// Optional watchdog is selected with CONTADOR_OBJETIVO_TIMEOUT_EN.
package contador_pkg;

   // Width of the counter, the latched target and the comparator operands.
   localparam int DEFAULT_WIDTH = 5;

   // Run sequencing: wait for a request, count towards the target, announce completion.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/contador_watchdog.sv
// Watchdog for contador_objetivo: counts COUNT cycles and flags when a run
// has spent 2^WIDTH cycles without ending. Only built with
// CONTADOR_OBJETIVO_TIMEOUT_EN defined.
module contador_watchdog
   import contador_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic restart,
   output logic expire
);

   // The last tolerated cycle is the 2^WIDTH-th one, i.e. index 2^WIDTH-1.
   // One extra bit keeps the counter from aliasing back to zero.
   localparam logic [WIDTH:0] LIMIT = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH:0] cycles_reg;

   // Cycle counter: cleared on every new run, advances while the run is counting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycles_reg <= '0;
      end else if (restart) begin
         cycles_reg <= '0;
      end else if (enable) begin
         cycles_reg <= cycles_reg + 1'b1;
      end
   end

   assign expire = enable && (cycles_reg == LIMIT);

endmodule

// File: rtl/contador_objetivo.sv
// contador_objetivo: latches a target on a start/ready handshake, counts
// cycles from zero, feeds count/target_q to an external equality comparator
// and ends the run when that comparator reports a match.
// Define CONTADOR_OBJETIVO_TIMEOUT_EN to add a watchdog that aborts runs
// which never match (err pulse); otherwise err is constant 0.
module contador_objetivo
   import contador_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] target,
   input  logic             clear,
   input  logic             match,
   output logic             ready,
   output logic             busy,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] target_q,
   output logic             done,
   output logic             err
);

   state_t           state_reg, state_next;
   logic [WIDTH-1:0] count_reg, count_next;
   logic [WIDTH-1:0] target_q_reg, target_q_next;

`ifdef CONTADOR_OBJETIVO_TIMEOUT_EN
   logic expire;
   logic err_reg, err_next;

   contador_watchdog #(
      .WIDTH (WIDTH)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .enable  (state_reg == COUNT),
      .restart ((state_reg == IDLE) && start),
      .expire  (expire)
   );
`endif

   // State, counter and latched target registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         target_q_reg <= '0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         target_q_reg <= target_q_next;
      end
   end

`ifdef CONTADOR_OBJETIVO_TIMEOUT_EN
   // err is registered so it shows up in the first idle cycle after an abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else begin
         err_reg <= err_next;
      end
   end
`endif

   // Next-state logic: clear beats match, match beats the watchdog.
   // match is only looked at while counting, since the comparator sees
   // stale operands in the other states.
   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      target_q_next = target_q_reg;
`ifdef CONTADOR_OBJETIVO_TIMEOUT_EN
      err_next      = 1'b0;
`endif
      case (state_reg)
         IDLE: begin
            if (start) begin
               target_q_next = target;
               count_next    = '0;
               state_next    = COUNT;
            end
         end
         COUNT: begin
            if (clear) begin
               count_next = '0;
               state_next = IDLE;
            end else if (match) begin
               state_next = DONE;
`ifdef CONTADOR_OBJETIVO_TIMEOUT_EN
            end else if (expire) begin
               count_next = '0;
               err_next   = 1'b1;
               state_next = IDLE;
`endif
            end else begin
               // Natural wrap modulo 2^WIDTH.
               count_next = count_reg + 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Status outputs decode straight from the state register, so an
   // asynchronous reset drops them in the same instant.
   assign ready    = (state_reg == IDLE);
   assign busy     = (state_reg == COUNT);
   assign done     = (state_reg == DONE);
   assign count    = count_reg;
   assign target_q = target_q_reg;

`ifdef CONTADOR_OBJETIVO_TIMEOUT_EN
   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_contador_objetivo.sv
// Directed testbench for contador_objetivo with a behavioural model of the
// downstream 5-bit equality comparator. Builds with or without
// CONTADOR_OBJETIVO_TIMEOUT_EN.
module tb_contador_objetivo;

   logic       clk;
   logic       rst;
   logic       start;
   logic [4:0] target;
   logic       clear;
   logic       match;
   logic       ready;
   logic       busy;
   logic [4:0] count;
   logic [4:0] target_q;
   logic       done;
   logic       err;

   // Comparator model controls: cmp_rst holds it in reset (match=0),
   // force_match injects a match regardless of operands.
   logic cmp_rst;
   logic force_match;

   int checks;
   int errors;

   assign match = force_match | (!cmp_rst && (count == target_q));

   contador_objetivo #(.WIDTH(5)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .target   (target),
      .clear    (clear),
      .match    (match),
      .ready    (ready),
      .busy     (busy),
      .count    (count),
      .target_q (target_q),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b expected 1", ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b expected 0", busy); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d expected 0", count); end
      checks++; if (target_q !== 5'd0) begin errors++; $display("FAIL reset_target_q got %0d expected 0", target_q); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b expected 0", done); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b expected 0", err); end
      $display("reset: ready=%0b count=%0d target_q=%0d", ready, count, target_q);
   endtask

   task automatic test_target5();
      start  = 1'b1;
      target = 5'd5;
      tick();                 // cycle T+1
      start  = 1'b0;
      target = 5'd0;
      for (int n = 0; n <= 5; n++) begin
         checks++; if (count !== n[4:0]) begin errors++; $display("FAIL t5_count[%0d] got %0d expected %0d", n, count, n); end
         checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL t5_busy[%0d] got busy=%0b done=%0b expected busy=1 done=0", n, busy, done); end
         tick();
      end
      // cycle T+7
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL t5_done got %0b expected 1", done); end
      checks++; if (count !== 5'd5 || target_q !== 5'd5) begin errors++; $display("FAIL t5_hold got count=%0d target_q=%0d expected 5/5", count, target_q); end
      checks++; if (ready !== 1'b0) begin errors++; $display("FAIL t5_ready_done got %0b expected 0", ready); end
      tick();                 // cycle T+8
      checks++; if (ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL t5_ready got ready=%0b done=%0b expected 1/0", ready, done); end
      $display("target5: run complete, count=%0d", count);
   endtask

   task automatic test_target0();
      start  = 1'b1;
      target = 5'd0;
      tick();                 // T+1
      start = 1'b0;
      checks++; if (busy !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL t0_count got busy=%0b count=%0d expected 1/0", busy, count); end
      tick();                 // T+2
      checks++; if (done !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL t0_done got done=%0b count=%0d expected 1/0", done, count); end
      tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL t0_ready got %0b expected 1", ready); end
      $display("target0: done seen at T+2");
   endtask

   task automatic test_abort_ignore();
      start  = 1'b1;
      target = 5'd20;
      tick();                 // count=0
      start = 1'b0;
      for (int n = 0; n < 7; n++) begin
         // Spurious start with a different target while busy.
         start  = (n >= 2 && n <= 4);
         target = 5'd3;
         tick();
      end
      start = 1'b0;
      checks++; if (count !== 5'd7) begin errors++; $display("FAIL abort_pre_count got %0d expected 7", count); end
      checks++; if (target_q !== 5'd20) begin errors++; $display("FAIL abort_ignored_start got target_q=%0d expected 20", target_q); end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle got ready=%0b busy=%0b expected 1/0", ready, busy); end
      checks++; if (count !== 5'd0 || done !== 1'b0) begin errors++; $display("FAIL abort_count got count=%0d done=%0b expected 0/0", count, done); end
      tick();
      checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL abort_nodone got done=%0b ready=%0b expected 0/1", done, ready); end
      // clear in IDLE must do nothing: a start in the same cycle is still taken.
      clear  = 1'b1;
      start  = 1'b1;
      target = 5'd1;
      tick();
      clear  = 1'b0;
      start  = 1'b0;
      checks++; if (busy !== 1'b1 || target_q !== 5'd1) begin errors++; $display("FAIL clear_idle got busy=%0b target_q=%0d expected 1/1", busy, target_q); end
      tick();                 // count=1 matches
      tick();                 // DONE
      clear = 1'b1;
      tick();                 // clear in DONE ignored, normal return to IDLE
      clear = 1'b0;
      checks++; if (ready !== 1'b1 || count !== 5'd1) begin errors++; $display("FAIL clear_done got ready=%0b count=%0d expected 1/1", ready, count); end
      $display("abort/ignore: target_q=%0d count=%0d", target_q, count);
   endtask

   task automatic test_midrun_reset();
      start  = 1'b1;
      target = 5'd10;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();                 // count=3
      checks++; if (count !== 5'd3) begin errors++; $display("FAIL rst_pre_count got %0d expected 3", count); end
      rst = 1'b1;
      #1;                     // no clock edge: reset is asynchronous
      checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL rst_async_state got ready=%0b busy=%0b expected 1/0", ready, busy); end
      checks++; if (count !== 5'd0 || target_q !== 5'd0) begin errors++; $display("FAIL rst_async_regs got count=%0d target_q=%0d expected 0/0", count, target_q); end
      checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_async_pulses got done=%0b err=%0b expected 0/0", done, err); end
      tick();
      rst = 1'b0;
      tick();
      $display("midrun reset: count=%0d ready=%0b", count, ready);
   endtask

   task automatic test_priority();
      start  = 1'b1;
      target = 5'd25;
      tick();
      start = 1'b0;
      tick();
      tick();                 // count=2
      clear       = 1'b1;
      force_match = 1'b1;
      tick();
      clear       = 1'b0;
      force_match = 1'b0;
      checks++; if (ready !== 1'b1 || done !== 1'b0 || count !== 5'd0) begin errors++; $display("FAIL prio_clear got ready=%0b done=%0b count=%0d expected 1/0/0", ready, done, count); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL prio_nodone got %0b expected 0", done); end
      // match alone from the comparator ends the run with count held.
      start  = 1'b1;
      target = 5'd25;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();                 // count=3
      force_match = 1'b1;
      tick();
      force_match = 1'b0;
      checks++; if (done !== 1'b1 || count !== 5'd3) begin errors++; $display("FAIL prio_match got done=%0b count=%0d expected 1/3", done, count); end
      tick();
      $display("priority: clear over match, forced match at count 3");
   endtask

   task automatic test_back_to_back();
      start  = 1'b1;          // held high throughout
      target = 5'd2;
      tick();                 // T+1 count=0
      tick();
      tick();                 // T+3 count=2
      checks++; if (count !== 5'd2 || busy !== 1'b1) begin errors++; $display("FAIL b2b_count got count=%0d busy=%0b expected 2/1", count, busy); end
      tick();                 // T+4 DONE
      checks++; if (done !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL b2b_done got done=%0b ready=%0b expected 1/0", done, ready); end
      tick();                 // T+5 IDLE, start accepted here
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %0b expected 1", ready); end
      tick();                 // T+6 second run
      start = 1'b0;
      checks++; if (busy !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL b2b_second got busy=%0b count=%0d expected 1/0", busy, count); end
      for (int n = 0; n < 4; n++) tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_end got %0b expected 1", ready); end
      $display("back-to-back: second run started at T+6");
   endtask

   task automatic test_watchdog();
      cmp_rst = 1'b1;
      start   = 1'b1;
      target  = 5'd9;
      tick();                 // first COUNT cycle
      start = 1'b0;
      for (int n = 0; n < 32; n++) begin
         checks++; if (busy !== 1'b1 || count !== n[4:0] || err !== 1'b0) begin errors++; $display("FAIL wd_run[%0d] got busy=%0b count=%0d err=%0b expected 1/%0d/0", n, busy, count, err, n); end
         tick();
      end
`ifdef CONTADOR_OBJETIVO_TIMEOUT_EN
      checks++; if (err !== 1'b1 || ready !== 1'b1 || count !== 5'd0) begin errors++; $display("FAIL wd_expire got err=%0b ready=%0b count=%0d expected 1/1/0", err, ready, count); end
      tick();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL wd_pulse got %0b expected 0", err); end
`else
      checks++; if (busy !== 1'b1 || count !== 5'd0 || err !== 1'b0) begin errors++; $display("FAIL wd_wrap got busy=%0b count=%0d err=%0b expected 1/0/0", busy, count, err); end
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++; if (ready !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL wd_clear got ready=%0b err=%0b expected 1/0", ready, err); end
`endif
      cmp_rst = 1'b0;
      tick();
      $display("watchdog: run ended, ready=%0b", ready);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rst         = 1'b1;
      start       = 1'b0;
      target      = 5'd0;
      clear       = 1'b0;
      cmp_rst     = 1'b0;
      force_match = 1'b0;
      test_reset();
      test_target5();
      test_target0();
      test_abort_ignore();
      test_midrun_reset();
      test_priority();
      test_back_to_back();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/contador_objetivo.md
# contador_objetivo

Sequential stage directly upstream of the 5-bit equality comparator in the multicycle datapath. It latches a target value on a start/ready handshake and counts cycles from zero. It drives the counter and latched target onto the comparator's `a`/`b` inputs and consumes the comparator's match output to end the run. Completion is a one-cycle `done` pulse; an optional watchdog aborts runs that never match.

## Interface
- `WIDTH`, default 5: width of the counter, the target and the comparator operands.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request a run; accepted only when `ready`=1.
- `target` in WIDTH: target value, sampled on the accepted `start`.
- `clear` in 1: synchronous abort; returns the block to idle.
- `match` in 1: equality result from the comparator (`count`==`target_q`).
- `ready` out 1: block idle, can accept `start`.
- `busy` out 1: run in progress.
- `count` out WIDTH: running count, drives comparator `a`.
- `target_q` out WIDTH: latched target, drives comparator `b`.
- `done` out 1: one-cycle pulse when a run ends on a match.
- `err` out 1: one-cycle pulse when the watchdog aborts a run.

## Operation
- Reset values: state IDLE, `count`=0, `target_q`=0, `ready`=1, `busy`=0, `done`=0, `err`=0.
- State machine:
  - IDLE: `ready`=1. On `start`: latch `target` into `target_q`, clear `count` to 0, go to COUNT. Without `start`, stay.
  - COUNT: `busy`=1, `ready`=0.
    - `clear`=1: go to IDLE, `count`=0.
    - Otherwise, `match`=1: go to DONE, `count` holds.
    - Otherwise: `count`+1, modulo 2^WIDTH (31 wraps to 0).
  - DONE: `done`=1 for exactly this cycle, `ready`=0, `count` and `target_q` hold. Next cycle goes to IDLE unconditionally.
- `start` while `ready`=0 is ignored; it is not queued.
- `clear` in IDLE or DONE has no effect.
- `clear` and `match` in the same COUNT cycle: `clear` wins; no `done`.
- `target`=0 matches in the first COUNT cycle.
- `match` is treated as combinational from `count`/`target_q`. The block never samples `match` outside COUNT.
- When the comparator is held in its own reset, `match`=0. The run then continues until `clear` or the watchdog ends it.
- `rst` asserted mid-run: immediate return to reset values. No `done` or `err`.

## Timing
- Handshake: `start` is accepted in cycle T when `ready`=1. COUNT begins at T+1 with `count`=0.
- For target N, `count`=N in cycle T+1+N. `done` is high in cycle T+2+N, and `ready` returns at T+3+N.
- Throughput: one run per N+3 cycles. Back-to-back `start` is held off by the DONE cycle.
- `err` timing: see Configuration.

## Configuration
- Macro `CONTADOR_OBJETIVO_TIMEOUT_EN`.
- Defined: a watchdog counts COUNT cycles. If 2^WIDTH COUNT cycles pass without `match` or `clear`, the block goes to IDLE, pulses `err` for one cycle and clears `count`. Watchdog priority is below `clear` and `match`. The watchdog counter resets on every entry into COUNT.
- Undefined: no watchdog. `err` is tied to 0, and a run without a match continues indefinitely, wrapping `count`.

## Structure
- Package `contador_pkg`:
  - `state_t` enum {IDLE, COUNT, DONE}.
  - `localparam` default WIDTH = 5.
- Sub-module `contador_watchdog`, instantiated only under the macro:
  - WIDTH+1-bit counter.
  - Inputs: `clk`, `rst`, `enable`, `restart`.
  - Output: `expire`.
- The comparator is instantiated by the parent, not inside this block.

## Test plan
- Reset release: `rst` 1→0 → `ready`=1, `count`=0, `target_q`=0, `done`=0, `err`=0.
- Target 5: `start` in cycle T with comparator model connected → `count` runs 0..5, `done` high only in cycle T+7, `ready` back at T+8.
- Target 0: `start` → `done` in cycle T+2; `count` stays 0.
- Abort and ignore: with target 20, assert `clear` at `count`=7 → IDLE with `count`=0 and no `done`. A `start` asserted during the run is not accepted.
- Mid-run reset and priority:
  - `rst` at `count`=3 → all outputs at reset values immediately.
  - Forcing `clear` and `match` together → IDLE, no `done`.
- Watchdog, with macro defined: hold `match`=0 after starting target 9 → `err` pulses after 32 COUNT cycles, then `ready`=1. Without the macro, `err` is never asserted and `count` wraps 31→0.
